// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: buffers pushed bytes and launches
// them one frame at a time, using tx_busy to find out when each frame ends.
module uart_tx_fifo #(
    parameter int unsigned DEPTH_LOG2   = 4,
    parameter int unsigned BUSY_TIMEOUT = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    input  logic                  ovf_clr,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  timeout,
    output logic                  active,
    output logic                  tx_start,
    output logic [7:0]            tx_data,
    input  logic                  tx_busy
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;
    localparam int unsigned TW    = (BUSY_TIMEOUT > 0) ? $clog2(BUSY_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_START     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            full_q, full_d;
    logic            empty_q, empty_d;
    logic            overflow_q, overflow_d;
    logic            timeout_q, timeout_d;
    logic            active_q, active_d;
    logic            tx_start_q, tx_start_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [7:0]      mem_q [DEPTH];

    logic            push_c;
    logic            pop_c;
    logic            ovf_set_c;
    logic            to_set_c;

    // Storage array; contents need no reset because pointers and count do.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
            active_q   <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            timeout_q  <= timeout_d;
            active_q   <= active_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            timer_q    <= timer_d;
        end
    end

    // Launch sequencer, FIFO bookkeeping and next values of registered outputs.
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        timer_d   = timer_q;
        tx_data_d = tx_data_q;
        pop_c     = 1'b0;
        to_set_c  = 1'b0;

        // Fullness is judged before any same-edge pop, so a pop never makes room.
        push_c    = wr_en && !full_q;
        ovf_set_c = wr_en && full_q;

        case (state_q)
            S_IDLE: begin
                if (!empty_q) begin
                    state_d   = S_START;
                    tx_data_d = mem_q[rd_ptr_q];
                    rd_ptr_d  = rd_ptr_q + PW'(1);
                    pop_c     = 1'b1;
                end
            end
            S_START: begin
                timer_d = '0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (timer_q == TW'(BUSY_TIMEOUT)) begin
                    state_d  = S_IDLE;
                    to_set_c = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end

        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        full_d     = (count_d == CW'(DEPTH));
        empty_d    = (count_d == '0);
        overflow_d = ovf_set_c || (overflow_q && !ovf_clr);
        timeout_d  = to_set_c  || (timeout_q  && !ovf_clr);
        tx_start_d = (state_d == S_START);
        active_d   = (state_d != S_IDLE) || !empty_d;
    end

    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign timeout  = timeout_q;
    assign active   = active_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: behavioural transmitter model plus per-scenario tasks.
module tb_uart_tx_fifo;

    localparam int M_NORMAL = 0;
    localparam int M_TIED0  = 1;
    localparam int M_STALL  = 2;
    localparam logic [18:0] RST_SNAP = {1'b0, 1'b1, 5'd0, 4'b0000, 8'h00};

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       ovf_clr;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       timeout;
    logic       active;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;

    int checks = 0;
    int errors = 0;

    // Transmitter model controls and observations.
    int         mode = M_NORMAL;
    bit         rel = 1'b0;
    int         hold_len = 40;
    bit         hold_rand = 1'b0;
    int         hold;
    logic       prev_start;
    int         starts = 0;
    int         viol = 0;
    logic [7:0] got[$];

    uart_tx_fifo #(.DEPTH_LOG2(4), .BUSY_TIMEOUT(7)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .ovf_clr  (ovf_clr),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .timeout  (timeout),
        .active   (active),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy)
    );

    always #5 clk = ~clk;

    // Transmitter: busy from the cycle after start, for hold cycles (or until released).
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_busy    <= 1'b0;
            hold       <= 0;
            prev_start <= 1'b0;
        end else begin
            prev_start <= tx_start;
            if (tx_start) begin
                starts <= starts + 1;
                got.push_back(tx_data);
                if (tx_busy || prev_start) viol <= viol + 1;
            end
            if (tx_start && mode != M_TIED0) begin
                tx_busy <= 1'b1;
                if (mode == M_STALL) hold <= 0;
                else hold <= (hold_rand ? int'($urandom_range(1, 12)) : hold_len) - 1;
            end else if (tx_busy) begin
                if (mode == M_STALL) begin
                    if (rel) tx_busy <= 1'b0;
                end else if (hold == 0) begin
                    tx_busy <= 1'b0;
                end else begin
                    hold <= hold - 1;
                end
            end
        end
    end

    task automatic wait_idle(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (active === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic push_bytes(input logic [7:0] b[$]);
        foreach (b[i]) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_data = b[i];
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Drops busy, lets the FSM return to IDLE, and pushes on the edge that pops.
    task automatic release_and_push(input logic [7:0] b);
        @(negedge clk); rel = 1'b1;
        @(negedge clk); rel = 1'b0;
        @(negedge clk); wr_en = 1'b1; wr_data = b;
        @(negedge clk); wr_en = 1'b0;
    endtask

    task automatic compare_stream(input string name, input logic [7:0] exp[$]);
        checks++;
        if (got.size() !== exp.size()) begin
            errors++;
            $display("FAIL %s_len: got %0d frames, expected %0d", name, got.size(), exp.size());
        end else begin
            foreach (exp[i]) begin
                checks++;
                if (got[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL %s[%0d]: got %h expected %h", name, i, got[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        logic [18:0] snap;
        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; ovf_clr = 1'b0;
        repeat (2) @(negedge clk);
        snap = {full, empty, count, overflow, timeout, active, tx_start, tx_data};
        checks++;
        if (snap !== RST_SNAP) begin
            errors++; $display("FAIL reset_state: got %h expected %h", snap, RST_SNAP);
        end
        rst = 1'b0;
    endtask

    task automatic test_latency();
        bit ok;
        int v0 = viol;
        logic [7:0] exp[$];
        got.delete();
        mode = M_NORMAL; hold_len = 40; hold_rand = 1'b0;
        @(negedge clk); wr_en = 1'b1; wr_data = 8'hA5;
        @(negedge clk); wr_en = 1'b0;
        checks++;
        if ({count, empty, active, tx_start} !== {5'd1, 1'b0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL lat_after_push: got cnt=%0d e=%b a=%b s=%b expected 1 0 1 0",
                               count, empty, active, tx_start);
        end
        @(negedge clk);
        checks++;
        if ({tx_start, tx_data, count, empty} !== {1'b1, 8'hA5, 5'd0, 1'b1}) begin
            errors++; $display("FAIL lat_launch: got s=%b d=%h cnt=%0d e=%b expected 1 a5 0 1",
                               tx_start, tx_data, count, empty);
        end
        @(negedge clk);
        checks++;
        if (tx_start !== 1'b0) begin
            errors++; $display("FAIL lat_single_pulse: got tx_start=%b expected 0", tx_start);
        end
        wait_idle(200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL lat_drain: got active=1 expected 0"); end
        exp.push_back(8'hA5);
        compare_stream("lat_stream", exp);
        checks++;
        if (viol !== v0) begin errors++; $display("FAIL lat_viol: got %0d expected %0d", viol, v0); end
    endtask

    task automatic test_in_order();
        bit ok;
        int v0 = viol;
        int s0 = starts;
        logic [7:0] exp[$];
        got.delete();
        mode = M_NORMAL; hold_len = 40; hold_rand = 1'b0;
        for (int i = 0; i < 16; i++) exp.push_back(8'(i));
        push_bytes(exp);
        wait_idle(1500, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL order_drain: got active=1 expected 0"); end
        compare_stream("order", exp);
        checks++;
        if (starts - s0 !== 16) begin
            errors++; $display("FAIL order_starts: got %0d expected 16", starts - s0);
        end
        checks++;
        if (viol !== v0) begin errors++; $display("FAIL order_viol: got %0d expected %0d", viol, v0); end
    endtask

    task automatic test_random_stream();
        bit ok;
        int v0 = viol;
        int n;
        int sent;
        logic [7:0] exp[$];
        got.delete();
        mode = M_NORMAL; hold_rand = 1'b1;
        for (int b = 0; b < 3; b++) begin
            n = $urandom_range(1, 16);
            sent = 0;
            while (sent < n) begin
                @(negedge clk);
                if ($urandom_range(0, 2) != 0) begin
                    wr_en = 1'b1; wr_data = 8'($urandom); exp.push_back(wr_data); sent++;
                end else begin
                    wr_en = 1'b0;
                end
            end
            @(negedge clk); wr_en = 1'b0;
            wait_idle(1000, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL rand_drain%0d: got active=1 expected 0", b); end
        end
        hold_rand = 1'b0;
        compare_stream("rand", exp);
        checks++;
        if ({count, empty, overflow} !== {5'd0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL rand_end: got cnt=%0d e=%b o=%b expected 0 1 0", count, empty, overflow);
        end
        checks++;
        if (viol !== v0) begin errors++; $display("FAIL rand_viol: got %0d expected %0d", viol, v0); end
    endtask

    task automatic test_overflow();
        bit ok;
        logic [7:0] exp[$];
        logic [7:0] fill[$];
        logic [7:0] one[$];
        got.delete();
        mode = M_STALL;
        one.push_back(8'($urandom));
        exp.push_back(one[0]);
        push_bytes(one);
        repeat (5) @(negedge clk);
        for (int i = 0; i < 16; i++) fill.push_back(8'($urandom));
        foreach (fill[i]) exp.push_back(fill[i]);
        push_bytes(fill);
        checks++;
        if ({count, full, overflow} !== {5'd16, 1'b1, 1'b0}) begin
            errors++; $display("FAIL ovf_full: got cnt=%0d f=%b o=%b expected 16 1 0", count, full, overflow);
        end
        @(negedge clk); wr_en = 1'b1; wr_data = 8'hEE;
        @(negedge clk); wr_en = 1'b0;
        checks++;
        if ({count, full, overflow} !== {5'd16, 1'b1, 1'b1}) begin
            errors++; $display("FAIL ovf_drop: got cnt=%0d f=%b o=%b expected 16 1 1", count, full, overflow);
        end
        ovf_clr = 1'b1;
        @(negedge clk); ovf_clr = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
        mode = M_NORMAL; hold_len = 4;
        wait_idle(1000, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL ovf_drain: got active=1 expected 0"); end
        compare_stream("ovf", exp);
    endtask

    task automatic test_full_pop();
        bit ok;
        logic [7:0] exp[$];
        logic [7:0] fill[$];
        logic [7:0] one[$];
        got.delete();
        mode = M_STALL;
        one.push_back(8'($urandom));
        exp.push_back(one[0]);
        push_bytes(one);
        repeat (5) @(negedge clk);
        for (int i = 0; i < 16; i++) fill.push_back(8'($urandom));
        foreach (fill[i]) exp.push_back(fill[i]);
        push_bytes(fill);
        release_and_push(8'h77);
        checks++;
        if ({count, full, overflow, tx_start, tx_data} !== {5'd15, 1'b0, 1'b1, 1'b1, fill[0]}) begin
            errors++; $display("FAIL fullpop_drop: got cnt=%0d f=%b o=%b s=%b d=%h expected 15 0 1 1 %h",
                               count, full, overflow, tx_start, tx_data, fill[0]);
        end
        repeat (5) @(negedge clk);
        release_and_push(8'h88);
        exp.push_back(8'h88);
        checks++;
        if ({count, full, tx_start, tx_data} !== {5'd15, 1'b0, 1'b1, fill[1]}) begin
            errors++; $display("FAIL fullpop_same_edge: got cnt=%0d f=%b s=%b d=%h expected 15 0 1 %h",
                               count, full, tx_start, tx_data, fill[1]);
        end
        ovf_clr = 1'b1;
        @(negedge clk); ovf_clr = 1'b0;
        mode = M_NORMAL; hold_len = 4;
        wait_idle(1500, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL fullpop_drain: got active=1 expected 0"); end
        compare_stream("fullpop", exp);
    endtask

    task automatic test_timeout();
        got.delete();
        mode = M_TIED0;
        @(negedge clk); wr_en = 1'b1; wr_data = 8'h3C;
        @(negedge clk); wr_data = 8'h5A;
        @(negedge clk); wr_en = 1'b0;
        checks++;
        if ({tx_start, tx_data, count} !== {1'b1, 8'h3C, 5'd1}) begin
            errors++; $display("FAIL to_launch: got s=%b d=%h cnt=%0d expected 1 3c 1", tx_start, tx_data, count);
        end
        for (int k = 2; k <= 20; k++) begin
            ovf_clr = (k == 12 || k == 20);
            @(negedge clk);
            if (k == 9) begin
                checks++;
                if (timeout !== 1'b0) begin errors++; $display("FAIL to_early: got %b expected 0", timeout); end
            end
            if (k == 10) begin
                checks++;
                if (timeout !== 1'b1) begin errors++; $display("FAIL to_set: got %b expected 1", timeout); end
            end
            if (k == 11) begin
                checks++;
                if ({tx_start, tx_data} !== {1'b1, 8'h5A}) begin
                    errors++; $display("FAIL to_next_launch: got s=%b d=%h expected 1 5a", tx_start, tx_data);
                end
            end
            if (k == 12) begin
                checks++;
                if (timeout !== 1'b0) begin errors++; $display("FAIL to_clear: got %b expected 0", timeout); end
            end
            if (k == 20) begin
                checks++;
                if ({timeout, active, empty} !== 3'b101) begin
                    errors++; $display("FAIL to_set_wins: got t=%b a=%b e=%b expected 1 0 1", timeout, active, empty);
                end
            end
        end
        ovf_clr = 1'b1;
        @(negedge clk); ovf_clr = 1'b0;
        mode = M_NORMAL;
    endtask

    task automatic test_reset_mid_frame();
        logic [18:0] snap;
        logic [7:0] six[$];
        int s0;
        mode = M_STALL;
        for (int i = 0; i < 6; i++) six.push_back(8'($urandom));
        push_bytes(six);
        repeat (5) @(negedge clk);
        checks++;
        if ({count, active} !== {5'd5, 1'b1}) begin
            errors++; $display("FAIL rstmid_pre: got cnt=%0d a=%b expected 5 1", count, active);
        end
        #2 rst = 1'b1;
        #1 snap = {full, empty, count, overflow, timeout, active, tx_start, tx_data};
        checks++;
        if (snap !== RST_SNAP) begin
            errors++; $display("FAIL rstmid_async: got %h expected %h", snap, RST_SNAP);
        end
        @(negedge clk); rst = 1'b0;
        mode = M_NORMAL;
        s0 = starts;
        repeat (60) @(negedge clk);
        checks++;
        if ({starts == s0, active, count} !== {1'b1, 1'b0, 5'd0}) begin
            errors++; $display("FAIL rstmid_no_resume: got starts=%0d a=%b cnt=%0d expected %0d 0 0",
                               starts, active, count, s0);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_in_order();
        test_random_stream();
        test_overflow();
        test_full_pop();
        test_timeout();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
